// File: rtl/pcie_msi_irq_ctrl_if.sv
// PCIe hard-IP cfg_interrupt_msi_* signal bundle between the MSI controller and the hard IP.
// Latency: none; this is wiring only.
// Backpressure: sent/fail from the hard IP complete each one-cycle msi_int request.
interface pcie_msi_irq_ctrl_if;
   logic        cfg_interrupt_msi_enable;
   logic [2:0]  cfg_interrupt_msi_mmenable;
   logic [31:0] cfg_interrupt_msi_int;
   logic        cfg_interrupt_msi_sent;
   logic        cfg_interrupt_msi_fail;
   logic [3:0]  cfg_interrupt_msi_function_number;
   logic [2:0]  cfg_interrupt_msi_attr;
   logic [3:0]  cfg_interrupt_msi_select;

   // Controller side: requests interrupts and consumes the status returned by the hard IP.
   modport master (
      input  cfg_interrupt_msi_enable,
      input  cfg_interrupt_msi_mmenable,
      input  cfg_interrupt_msi_sent,
      input  cfg_interrupt_msi_fail,
      output cfg_interrupt_msi_int,
      output cfg_interrupt_msi_function_number,
      output cfg_interrupt_msi_attr,
      output cfg_interrupt_msi_select
   );

   // Hard-IP side.
   modport slave (
      output cfg_interrupt_msi_enable,
      output cfg_interrupt_msi_mmenable,
      output cfg_interrupt_msi_sent,
      output cfg_interrupt_msi_fail,
      input  cfg_interrupt_msi_int,
      input  cfg_interrupt_msi_function_number,
      input  cfg_interrupt_msi_attr,
      input  cfg_interrupt_msi_select
   );
endinterface

// File: rtl/pcie_msi_irq_ctrl.sv
// Per-vector MSI controller: pending set, round-robin issue, sent/fail handshake, retry back-off.
// Latency: an irq_req pulse in cycle N drives msi_int in cycle N+2 when idle with no back-off.
// Backpressure: one MSI in flight; new requests wait in the pending set until sent/fail/timeout.
module pcie_msi_irq_ctrl #(
   parameter int MSI_COUNT    = 32,
   parameter int RETRY_DELAY  = 64,
   parameter int WAIT_TIMEOUT = 1024
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [MSI_COUNT-1:0] irq_req,
   output logic [MSI_COUNT-1:0] irq_pending,
   output logic [15:0]          fail_count,
   pcie_msi_irq_ctrl_if.master  msi
);
   localparam int BCW = $clog2(RETRY_DELAY + 1);
   localparam int WCW = $clog2(WAIT_TIMEOUT + 1);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ISSUE = 2'd1;
   localparam logic [1:0] WAIT  = 2'd2;

   logic [1:0]           state;
   logic [31:0]          pending;
   logic [31:0]          msi_int_q;
   logic [15:0]          fail_cnt;
   logic [4:0]           rr_ptr;
   logic [4:0]           grant;
   logic [BCW-1:0]       backoff;
   logic [WCW-1:0]       wait_cnt;

   logic [31:0]          en_mask;
   logic [31:0]          eligible;
   logic [31:0]          clr;
   logic [4:0]           pick;
   logic [4:0]           idx;
   logic                 found;
   logic                 timeout;

   assign irq_pending = pending;
   assign fail_count  = fail_cnt;
   assign msi.cfg_interrupt_msi_int             = msi_int_q;
   assign msi.cfg_interrupt_msi_function_number = 4'd0;
   assign msi.cfg_interrupt_msi_attr            = 3'd0;
   assign msi.cfg_interrupt_msi_select          = 4'd0;

   // Vectors above the allocated count (2**mmenable) stay pending but are not eligible.
   always_comb begin
      en_mask = '0;
      for (int i = 0; i < 32; i++) begin
         en_mask[i] = (msi.cfg_interrupt_msi_mmenable >= 3'd5) ||
                      (5'(i) < (5'd1 << msi.cfg_interrupt_msi_mmenable));
      end
   end

   assign eligible = pending & en_mask;
   assign clr      = (state == WAIT && msi.cfg_interrupt_msi_sent) ? (32'd1 << grant) : 32'd0;
   assign timeout  = (wait_cnt == WCW'(WAIT_TIMEOUT - 1));

   // Round-robin pick: first eligible index at or above rr_ptr, wrapping through 31 to 0.
   always_comb begin
      pick  = '0;
      idx   = '0;
      found = 1'b0;
      for (int k = 0; k < 32; k++) begin
         idx = rr_ptr + 5'(k);
         if (!found && eligible[idx]) begin
            pick  = idx;
            found = 1'b1;
         end
      end
   end

   // Pending set, back-off timer, issue FSM and failure counter.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         pending   <= '0;
         msi_int_q <= '0;
         fail_cnt  <= '0;
         rr_ptr    <= '0;
         grant     <= '0;
         backoff   <= '0;
         wait_cnt  <= '0;
      end else begin
         // A same-cycle request on the acknowledged vector re-arms it.
         pending <= (pending | irq_req) & ~clr | irq_req;
         if (backoff != '0) backoff <= backoff - BCW'(1);
         case (state)
            IDLE: begin
               if (msi.cfg_interrupt_msi_enable && eligible != '0 && backoff == '0) begin
                  grant     <= pick;
                  msi_int_q <= 32'd1 << pick;
                  state     <= ISSUE;
               end
            end
            ISSUE: begin
               msi_int_q <= '0;
               wait_cnt  <= '0;
               state     <= WAIT;
            end
            WAIT: begin
               // sent takes priority over a simultaneous fail.
               if (msi.cfg_interrupt_msi_sent) begin
                  rr_ptr <= grant + 5'd1;
                  state  <= IDLE;
               end else if (msi.cfg_interrupt_msi_fail || timeout) begin
                  if (fail_cnt != 16'hFFFF) fail_cnt <= fail_cnt + 16'd1;
                  backoff <= BCW'(RETRY_DELAY);
                  rr_ptr  <= grant + 5'd1;
                  state   <= IDLE;
               end else begin
                  wait_cnt <= wait_cnt + WCW'(1);
               end
            end
            default: begin
               msi_int_q <= '0;
               state     <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_pcie_msi_irq_ctrl.sv
// Directed bench for pcie_msi_irq_ctrl: latency, round-robin order, fail/timeout retry,
// vector masking, enable gating and reset during WAIT.
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_pcie_msi_irq_ctrl;
   localparam int RD = 8;
   localparam int WT = 20;

   logic        clk;
   logic        rst_n;
   logic [31:0] irq_req;
   logic [31:0] irq_pending;
   logic [15:0] fail_count;
   int          n_cmp;
   int          n_err;

   pcie_msi_irq_ctrl_if msi_if ();

   pcie_msi_irq_ctrl #(.MSI_COUNT(32), .RETRY_DELAY(RD), .WAIT_TIMEOUT(WT)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .irq_req     (irq_req),
      .irq_pending (irq_pending),
      .fail_count  (fail_count),
      .msi         (msi_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Advance until msi_int is nonzero (bounded); v is 0 if the bound expires.
   task automatic wait_issue(output logic [31:0] v, output int cyc);
      cyc = 0;
      while (msi_if.cfg_interrupt_msi_int == 32'd0 && cyc < 200) begin
         tick();
         cyc++;
      end
      v = msi_if.cfg_interrupt_msi_int;
   endtask

   // Pulse sent d cycles after the current (issue) cycle.
   task automatic ack_after(input int d);
      repeat (d) tick();
      msi_if.cfg_interrupt_msi_sent = 1'b1;
      tick();
      msi_if.cfg_interrupt_msi_sent = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      n_cmp++; if (irq_pending !== 32'd0) begin n_err++; $display("FAIL reset_pending: got %h exp 0", irq_pending); end
      n_cmp++; if (fail_count !== 16'd0) begin n_err++; $display("FAIL reset_fail_count: got %h exp 0", fail_count); end
      n_cmp++; if (msi_if.cfg_interrupt_msi_int !== 32'd0) begin n_err++; $display("FAIL reset_msi_int: got %h exp 0", msi_if.cfg_interrupt_msi_int); end
      n_cmp++;
      if ({msi_if.cfg_interrupt_msi_function_number, msi_if.cfg_interrupt_msi_attr, msi_if.cfg_interrupt_msi_select} !== 11'd0) begin
         n_err++; $display("FAIL reset_const_outputs: got %h exp 0",
            {msi_if.cfg_interrupt_msi_function_number, msi_if.cfg_interrupt_msi_attr, msi_if.cfg_interrupt_msi_select});
      end
   endtask

   task automatic test_latency();
      irq_req = 32'h8;                          // cycle N
      tick();
      irq_req = 32'h0;                          // N+1
      n_cmp++; if (irq_pending !== 32'h8) begin n_err++; $display("FAIL lat_pending_n1: got %h exp 8", irq_pending); end
      n_cmp++; if (msi_if.cfg_interrupt_msi_int !== 32'h0) begin n_err++; $display("FAIL lat_int_n1: got %h exp 0", msi_if.cfg_interrupt_msi_int); end
      tick();                                   // N+2
      n_cmp++; if (msi_if.cfg_interrupt_msi_int !== 32'h8) begin n_err++; $display("FAIL lat_int_n2: got %h exp 8", msi_if.cfg_interrupt_msi_int); end
      tick();                                   // N+3
      n_cmp++; if (msi_if.cfg_interrupt_msi_int !== 32'h0) begin n_err++; $display("FAIL lat_int_n3: got %h exp 0", msi_if.cfg_interrupt_msi_int); end
      tick();
      tick();                                   // N+5
      n_cmp++; if (irq_pending !== 32'h8) begin n_err++; $display("FAIL lat_pending_n5: got %h exp 8", irq_pending); end
      msi_if.cfg_interrupt_msi_sent = 1'b1;
      tick();                                   // N+6
      msi_if.cfg_interrupt_msi_sent = 1'b0;
      n_cmp++; if (irq_pending !== 32'h0) begin n_err++; $display("FAIL lat_pending_n6: got %h exp 0", irq_pending); end
   endtask

   task automatic test_round_robin();
      logic [31:0] v;
      int          c;
      logic [31:0] exp_seq [3];
      do_reset();
      irq_req = 32'h8001;
      tick();
      irq_req = 32'h0;
      wait_issue(v, c);
      n_cmp++; if (v !== 32'h1) begin n_err++; $display("FAIL rr_first: got %h exp 1", v); end
      ack_after(3);
      wait_issue(v, c);
      n_cmp++; if (v !== 32'h8000) begin n_err++; $display("FAIL rr_second: got %h exp 8000", v); end
      ack_after(3);
      // Pointer now 16: bits 0,10,20 must go 20, then wrap to 0, then 10.
      exp_seq[0] = 32'h0010_0000;
      exp_seq[1] = 32'h0000_0001;
      exp_seq[2] = 32'h0000_0400;
      irq_req = 32'h0010_0401;
      tick();
      irq_req = 32'h0;
      for (int i = 0; i < 3; i++) begin
         wait_issue(v, c);
         n_cmp++; if (v !== exp_seq[i]) begin n_err++; $display("FAIL rr_wrap_%0d: got %h exp %h", i, v, exp_seq[i]); end
         ack_after(3);
      end
      n_cmp++; if (irq_pending !== 32'h0) begin n_err++; $display("FAIL rr_pending_drained: got %h exp 0", irq_pending); end
   endtask

   task automatic test_fail_retry();
      logic [31:0] v;
      int          c;
      irq_req = 32'h4;
      tick();
      irq_req = 32'h0;
      wait_issue(v, c);
      n_cmp++; if (v !== 32'h4) begin n_err++; $display("FAIL fail_issue: got %h exp 4", v); end
      tick();
      tick();
      msi_if.cfg_interrupt_msi_fail = 1'b1;     // cycle F
      tick();
      msi_if.cfg_interrupt_msi_fail = 1'b0;
      n_cmp++; if (fail_count !== 16'd1) begin n_err++; $display("FAIL fail_count_1: got %0d exp 1", fail_count); end
      n_cmp++; if (irq_pending[2] !== 1'b1) begin n_err++; $display("FAIL fail_pending_kept: got %b exp 1", irq_pending[2]); end
      wait_issue(v, c);
      n_cmp++; if (v !== 32'h4) begin n_err++; $display("FAIL fail_reissue_vec: got %h exp 4", v); end
      n_cmp++; if (c + 1 !== RD + 2) begin n_err++; $display("FAIL fail_reissue_delay: got %0d exp %0d", c + 1, RD + 2); end
      ack_after(2);
      n_cmp++; if (irq_pending !== 32'h0) begin n_err++; $display("FAIL fail_pending_cleared: got %h exp 0", irq_pending); end
   endtask

   task automatic test_timeout();
      logic [31:0] v;
      int          c;
      irq_req = 32'h20;
      tick();
      irq_req = 32'h0;
      wait_issue(v, c);
      n_cmp++; if (v !== 32'h20) begin n_err++; $display("FAIL to_issue: got %h exp 20", v); end
      tick();
      wait_issue(v, c);
      n_cmp++; if (v !== 32'h20) begin n_err++; $display("FAIL to_reissue_vec: got %h exp 20", v); end
      n_cmp++; if (c !== WT + RD + 1) begin n_err++; $display("FAIL to_reissue_delay: got %0d exp %0d", c, WT + RD + 1); end
      n_cmp++; if (fail_count !== 16'd2) begin n_err++; $display("FAIL to_fail_count: got %0d exp 2", fail_count); end
      tick();
      tick();
      msi_if.cfg_interrupt_msi_sent = 1'b1;
      msi_if.cfg_interrupt_msi_fail = 1'b1;
      tick();
      msi_if.cfg_interrupt_msi_sent = 1'b0;
      msi_if.cfg_interrupt_msi_fail = 1'b0;
      n_cmp++; if (fail_count !== 16'd2) begin n_err++; $display("FAIL both_fail_count: got %0d exp 2", fail_count); end
      n_cmp++; if (irq_pending !== 32'h0) begin n_err++; $display("FAIL both_pending: got %h exp 0", irq_pending); end
      // No back-off after a sent: a new request issues with minimum latency.
      irq_req = 32'h40;
      tick();
      irq_req = 32'h0;
      wait_issue(v, c);
      n_cmp++; if (v !== 32'h40 || c !== 1) begin n_err++; $display("FAIL both_no_backoff: got %h after %0d exp 40 after 1", v, c); end
      ack_after(3);
   endtask

   task automatic test_mask_enable();
      logic [31:0] v;
      int          c;
      logic        seen;
      msi_if.cfg_interrupt_msi_mmenable = 3'd2;
      irq_req = 32'h80;
      tick();
      irq_req = 32'h0;
      seen = 1'b0;
      repeat (12) begin
         if (msi_if.cfg_interrupt_msi_int != 32'd0) seen = 1'b1;
         tick();
      end
      n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL mask_no_issue: got issue exp none"); end
      n_cmp++; if (irq_pending !== 32'h80) begin n_err++; $display("FAIL mask_pending: got %h exp 80", irq_pending); end
      msi_if.cfg_interrupt_msi_mmenable = 3'd3;
      wait_issue(v, c);
      n_cmp++; if (v !== 32'h80) begin n_err++; $display("FAIL mask_raised_issue: got %h exp 80", v); end
      ack_after(3);
      msi_if.cfg_interrupt_msi_mmenable = 3'd5;
      msi_if.cfg_interrupt_msi_enable = 1'b0;
      irq_req = 32'h2;
      tick();
      irq_req = 32'h0;
      seen = 1'b0;
      repeat (12) begin
         if (msi_if.cfg_interrupt_msi_int != 32'd0) seen = 1'b1;
         tick();
      end
      n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL dis_no_issue: got issue exp none"); end
      n_cmp++; if (irq_pending !== 32'h2) begin n_err++; $display("FAIL dis_pending: got %h exp 2", irq_pending); end
      msi_if.cfg_interrupt_msi_enable = 1'b1;
      wait_issue(v, c);
      n_cmp++; if (v !== 32'h2) begin n_err++; $display("FAIL dis_reenable_issue: got %h exp 2", v); end
      ack_after(3);
   endtask

   task automatic test_reset_in_wait();
      logic [31:0] v;
      int          c;
      irq_req = 32'h10;
      tick();
      irq_req = 32'h0;
      wait_issue(v, c);
      tick();                                   // in WAIT
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      n_cmp++; if (irq_pending !== 32'h0) begin n_err++; $display("FAIL rstw_pending: got %h exp 0", irq_pending); end
      n_cmp++; if (fail_count !== 16'd0) begin n_err++; $display("FAIL rstw_fail_count: got %0d exp 0", fail_count); end
      n_cmp++; if (msi_if.cfg_interrupt_msi_int !== 32'h0) begin n_err++; $display("FAIL rstw_msi_int: got %h exp 0", msi_if.cfg_interrupt_msi_int); end
      msi_if.cfg_interrupt_msi_sent = 1'b1;
      tick();
      msi_if.cfg_interrupt_msi_sent = 1'b0;
      msi_if.cfg_interrupt_msi_fail = 1'b1;
      tick();
      msi_if.cfg_interrupt_msi_fail = 1'b0;
      tick();
      n_cmp++; if (fail_count !== 16'd0) begin n_err++; $display("FAIL late_fail_count: got %0d exp 0", fail_count); end
      n_cmp++; if (irq_pending !== 32'h0 || msi_if.cfg_interrupt_msi_int !== 32'h0) begin
         n_err++; $display("FAIL late_state: got pending %h int %h exp 0 0", irq_pending, msi_if.cfg_interrupt_msi_int);
      end
      irq_req = 32'h200;
      tick();
      irq_req = 32'h0;
      wait_issue(v, c);
      n_cmp++; if (v !== 32'h200 || c !== 1) begin n_err++; $display("FAIL post_reset_issue: got %h after %0d exp 200 after 1", v, c); end
      ack_after(3);
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      rst_n = 1'b0;
      irq_req = 32'h0;
      msi_if.cfg_interrupt_msi_enable   = 1'b1;
      msi_if.cfg_interrupt_msi_mmenable = 3'd5;
      msi_if.cfg_interrupt_msi_sent     = 1'b0;
      msi_if.cfg_interrupt_msi_fail     = 1'b0;
      #1;
      test_reset();
      test_latency();
      test_round_robin();
      test_fail_retry();
      test_timeout();
      test_mask_enable();
      test_reset_in_wait();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
